// File: rtl/vga_out.sv
// vga_out: free-running 640x480@60 timing generator that sinks one AXI4-Stream pixel per visible clock.
// RGB, syncs and frame-sync all leave through one register stage, so every pin shares the same latency.
module vga_out #(
    parameter int BITS_PER_COLOR_CHANNEL = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic                              i_Clock,
    input  logic                              i_Reset_n,
    input  logic [15:0]                       s_axis_tdata,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic                              o_mm2s_fsync,
    output logic [BITS_PER_COLOR_CHANNEL-1:0] o_Red,
    output logic [BITS_PER_COLOR_CHANNEL-1:0] o_Green,
    output logic [BITS_PER_COLOR_CHANNEL-1:0] o_Blue,
    output logic                              o_Horizontal_Sync,
    output logic                              o_Vertical_Sync
);
    localparam int K       = BITS_PER_COLOR_CHANNEL;
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_VIS_END = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_START  = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END    = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_VIS_END = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_START  = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END    = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    function automatic logic [K-1:0] red_of(input logic [15:0] d);
        return d[3*K-1:2*K];
    endfunction

    function automatic logic [K-1:0] green_of(input logic [15:0] d);
        return d[2*K-1:K];
    endfunction

    function automatic logic [K-1:0] blue_of(input logic [15:0] d);
        return d[K-1:0];
    endfunction

    logic [HW-1:0] h_count_p0;
    logic [VW-1:0] v_count_p0;
    logic          vld_p0;

    // Stage p0: raster position and handshake; tready never looks at tvalid.
    assign vld_p0        = (h_count_p0 < H_VIS_END) && (v_count_p0 < V_VIS_END);
    assign s_axis_tready = vld_p0 && i_Reset_n;

    if (3 * K < 16) begin : g_unused
        logic unused_tdata;
        assign unused_tdata = ^s_axis_tdata[15:3*K];
    end

    // Stage p1: registered pins, all derived from the p0 position.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            h_count_p0        <= '0;
            v_count_p0        <= '0;
            o_Red             <= '0;
            o_Green           <= '0;
            o_Blue            <= '0;
            o_Horizontal_Sync <= 1'b1;
            o_Vertical_Sync   <= 1'b1;
            o_mm2s_fsync      <= 1'b0;
        end else begin
            if (h_count_p0 == H_LAST) begin
                h_count_p0 <= '0;
                v_count_p0 <= (v_count_p0 == V_LAST) ? '0 : v_count_p0 + 1'b1;
            end else begin
                h_count_p0 <= h_count_p0 + 1'b1;
            end

            // Underflow and blanking both show black; the raster never stalls.
            if (vld_p0 && s_axis_tvalid) begin
                o_Red   <= red_of(s_axis_tdata);
                o_Green <= green_of(s_axis_tdata);
                o_Blue  <= blue_of(s_axis_tdata);
            end else begin
                o_Red   <= '0;
                o_Green <= '0;
                o_Blue  <= '0;
            end

            o_Horizontal_Sync <= !((h_count_p0 >= HS_START) && (h_count_p0 < HS_END));
            o_Vertical_Sync   <= !((v_count_p0 >= VS_START) && (v_count_p0 < VS_END));
            o_mm2s_fsync      <= (h_count_p0 == '0) && (v_count_p0 == V_VIS_END);
        end
    end
endmodule

// File: tb/tb_vga_out.sv
// Directed bench for vga_out: full horizontal timing, vertical timing shortened to 10 lines
// (4 visible, 2 front, 2 sync, 2 back) so a whole frame is 8000 clocks.
module tb_vga_out;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        fsync;
    logic [3:0]  red, green, blue;
    logic        hs, vs;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_out #(
        .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) dut (
        .i_Clock           (clk),
        .i_Reset_n         (rst_n),
        .s_axis_tdata      (tdata),
        .s_axis_tvalid     (tvalid),
        .s_axis_tready     (tready),
        .o_mm2s_fsync      (fsync),
        .o_Red             (red),
        .o_Green           (green),
        .o_Blue            (blue),
        .o_Horizontal_Sync (hs),
        .o_Vertical_Sync   (vs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int beats, line0_beats, hs_low0, hs_first, hs_second, vs_low, vs_first;
        int fs_cnt, fs_at, late_ready, pix_err, ready_err, black;
        logic prev_hs, acc, exp_vis;
        logic [15:0] d;

        // Reset held for 5 clocks
        rst_n  = 1'b0;
        tvalid = 1'b0;
        tdata  = 16'h0;
        repeat (5) tick();
        chk("rst_rgb",    {red, green, blue}, 12'h000);
        chk("rst_hsync",  hs, 1'b1);
        chk("rst_vsync",  vs, 1'b1);
        chk("rst_fsync",  fsync, 1'b0);
        chk("rst_tready", tready, 1'b0);

        rst_n = 1'b1;
        #1;
        chk("rel_tready", tready, 1'b1);

        // One full frame of streaming with incrementing pixel data
        beats = 0; line0_beats = 0; hs_low0 = 0; hs_first = -1; hs_second = -1;
        vs_low = 0; vs_first = -1; fs_cnt = 0; fs_at = -1; late_ready = 0;
        pix_err = 0; ready_err = 0; prev_hs = 1'b1;
        tvalid = 1'b1;
        tdata  = 16'h0;
        for (int c = 0; c < 8000; c++) begin
            exp_vis = ((c % 800) < 640) && ((c / 800) < 4);
            if (tready !== exp_vis) ready_err++;
            acc = tvalid && tready;
            if (acc && c < 800) line0_beats++;
            if (tready && c >= 3200) late_ready++;
            d = tdata;
            tick();
            if (acc) begin
                if ({red, green, blue} !== d[11:0]) pix_err++;
                beats++;
                tdata = tdata + 16'h1;
            end else if ({red, green, blue} !== 12'h000) begin
                pix_err++;
            end
            if (!hs && c < 800) hs_low0++;
            if (!hs && prev_hs) begin
                if (hs_first < 0) hs_first = c;
                else if (hs_second < 0) hs_second = c;
            end
            prev_hs = hs;
            if (!vs) begin
                vs_low++;
                if (vs_first < 0) vs_first = c;
            end
            if (fsync) begin
                fs_cnt++;
                fs_at = c;
            end
        end
        chk("frame_beats",   beats, 2560);
        chk("line0_beats",   line0_beats, 640);
        chk("ready_pattern", ready_err, 0);
        chk("pixel_data",    pix_err, 0);
        chk("hsync_low_len", hs_low0, 96);
        chk("hsync_start",   hs_first, 656);
        chk("line_period",   hs_second - hs_first, 800);
        chk("vsync_low_len", vs_low, 1600);
        chk("vsync_start",   vs_first, 4800);
        chk("fsync_count",   fs_cnt, 1);
        chk("fsync_pos",     fs_at, 3200);
        chk("late_ready",    late_ready, 0);
        chk("wrap_tready",   tready, 1'b1);

        // Colour slicing at (0,0) of the second frame
        tdata = 16'h0ABC;
        tick();
        chk("slice_red",   red, 4'hA);
        chk("slice_green", green, 4'hB);
        chk("slice_blue",  blue, 4'hC);

        // Underflow for 10 visible clocks, positions 1..10
        tvalid = 1'b0;
        black  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ({red, green, blue} === 12'h000) black++;
        end
        chk("underflow_black", black, 10);
        tvalid = 1'b1;
        tdata  = 16'h0123;
        tick();
        chk("resume_pixel", {red, green, blue}, 12'h123);

        // Advance to column 656; sync timing unaffected by the underflow
        repeat (644) tick();
        chk("pre_hsync", hs, 1'b1);
        tdata = 16'h0FFF;
        chk("blank_tready", tready, 1'b0);
        tick();
        chk("blank_hsync", hs, 1'b0);
        chk("blank_rgb",   {red, green, blue}, 12'h000);

        // Run to line 2, column 300 with white pixels, then reset between edges
        repeat (1243) tick();
        chk("pre_reset_rgb", {red, green, blue}, 12'hFFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rgb",    {red, green, blue}, 12'h000);
        chk("async_tready", tready, 1'b0);
        chk("async_hsync",  hs, 1'b1);
        chk("async_vsync",  vs, 1'b1);
        chk("async_fsync",  fsync, 1'b0);

        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        chk("restart_tready", tready, 1'b1);
        repeat (656) tick();
        chk("restart_hsync_hi", hs, 1'b1);
        tick();
        chk("restart_hsync_lo", hs, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
